// File: rtl/fx_mul.sv
// Sequential sign-magnitude Qm.n multiplier with shift-add, one multiplier bit per clock.
// Optional round-half-up of the magnitude when FX_MUL_ROUND_EN is defined (truncates otherwise).
module fx_mul #(
    parameter int unsigned Q = 15,
    parameter int unsigned N = 32
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic [N-1:0] multiplicand_in,
    input  logic [N-1:0] multiplier_in,
    input  logic         start_in,
    output logic [N-1:0] product_out,
    output logic         complete_out,
    output logic         overflow_out
);

    localparam int unsigned AccW = 2 * N - 2;
    localparam int unsigned CntW = $clog2(N);

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    state_t          state_q;
    logic [AccW-1:0] a_q;
    logic [N-2:0]    b_q;
    logic [AccW-1:0] acc_q;
    logic [CntW-1:0] cnt_q;
    logic            sign_q;

    logic [AccW-1:0] acc_sum;
    logic [N-2:0]    mag;
    logic [N-2:0]    mag_sat;
    logic            ovf;
    logic [N-1:0]    result;
    logic            unused_low;
`ifdef FX_MUL_ROUND_EN
    logic [N-1:0]    rounded;
`endif

    // Final result is formed from the accumulator including this edge's partial product.
    always_comb begin
        acc_sum = acc_q + (b_q[0] ? a_q : '0);
`ifdef FX_MUL_ROUND_EN
        rounded = {1'b0, acc_sum[N-2+Q:Q]} + N'(acc_sum[Q-1]);
        ovf     = (|acc_sum[AccW-1:N-1+Q]) | rounded[N-1];
        mag     = rounded[N-2:0];
`else
        ovf     = |acc_sum[AccW-1:N-1+Q];
        mag     = acc_sum[N-2+Q:Q];
`endif
        mag_sat = ovf ? '1 : mag;
        // No negative zero: sign only survives with a nonzero magnitude.
        result  = {sign_q & (|mag_sat), mag_sat};
    end

    assign unused_low = ^acc_sum[Q-1:0];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            sign_q       <= 1'b0;
            product_out  <= '0;
            complete_out <= 1'b1;
            overflow_out <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_in) begin
                        a_q          <= {{(N - 1){1'b0}}, multiplicand_in[N-2:0]};
                        b_q          <= multiplier_in[N-2:0];
                        sign_q       <= multiplicand_in[N-1] ^ multiplier_in[N-1];
                        acc_q        <= '0;
                        cnt_q        <= CntW'(N - 2);
                        overflow_out <= 1'b0;
                        complete_out <= 1'b0;
                        state_q      <= StRun;
                    end
                end
                StRun: begin
                    acc_q <= acc_sum;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        product_out  <= result;
                        overflow_out <= ovf;
                        complete_out <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
